// File: rtl/pi_control_mc_if.sv
// Request/result handshake bundle for the multi-channel PI controller.
interface pi_control_mc_if #(
    parameter int N_CH    = 4,
    parameter int N_WIDTH = 17,
    parameter int GAIN_W  = 17,
    parameter int PWM_W   = 8
);
    localparam int CH_W = $clog2(N_CH) + 1;

    logic                      in_valid;
    logic                      in_ready;
    logic [CH_W-1:0]           in_ch;
    logic signed [N_WIDTH-1:0] in_error;
    logic [GAIN_W-1:0]         kp;
    logic [GAIN_W-1:0]         ki;
    logic                      out_valid;
    logic                      out_ready;
    logic [CH_W-1:0]           out_ch;
    logic [PWM_W-1:0]          out_pwm;
    logic                      out_err;

    modport master (
        output in_valid, in_ch, in_error, kp, ki, out_ready,
        input  in_ready, out_valid, out_ch, out_pwm, out_err
    );

    modport slave (
        input  in_valid, in_ch, in_error, kp, ki, out_ready,
        output in_ready, out_valid, out_ch, out_pwm, out_err
    );
endinterface

// File: rtl/pi_control_mc.sv
// Time-multiplexed incremental PI speed controller: N_CH channels share one multiplier.
// Optional macro PI_ANTIWINDUP_EN: u[k-1] history keeps the PWM-clamped value instead of the raw sum.
module pi_control_mc #(
    parameter int N_CH    = 4,
    parameter int N_WIDTH = 17,
    parameter int Q       = 8,
    parameter int GAIN_W  = 17,
    parameter int ACC_W   = 32,
    parameter int PWM_W   = 8,
    parameter int HI_THR  = 250,
    parameter int LO_THR  = 5
) (
    input  logic                  Prescaler_clk,
    input  logic                  Reset_n,
    input  logic                  clear_all,
    pi_control_mc_if.slave        req_if,
    output logic [N_CH*PWM_W-1:0] pwm_bus
);
    localparam int CH_W  = $clog2(N_CH) + 1;
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DIF_W = N_WIDTH + 2;
    localparam int PRD_W = DIF_W + GAIN_W + 1;
    localparam int SUM_W = ACC_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_P = 3'd1,
        ST_MUL_I = 3'd2,
        ST_ACC   = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    state_t                    state_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic                      out_err_q;
    logic [CH_W-1:0]           ch_q;
    logic [CH_W-1:0]           out_ch_q;
    logic [PWM_W-1:0]          out_pwm_q;
    logic signed [N_WIDTH-1:0] e_q;
    logic [GAIN_W-1:0]         kp_q;
    logic [GAIN_W-1:0]         ki_q;
    logic signed [SUM_W-1:0]   p_q;
    logic signed [SUM_W-1:0]   i_q;
    logic [N_CH*PWM_W-1:0]     pwm_bus_q;
    logic signed [N_WIDTH-1:0] e1_q [N_CH];
    logic signed [ACC_W-1:0]   u1_q [N_CH];

    logic                      ch_ok_d;
    logic [IDX_W-1:0]          idx_d;
    logic signed [N_WIDTH-1:0] e1_d;
    logic signed [ACC_W-1:0]   u1_d;
    logic signed [DIF_W-1:0]   mul_a_d;
    logic signed [GAIN_W:0]    mul_b_d;
    logic signed [PRD_W-1:0]   prod_d;
    logic signed [SUM_W-1:0]   prod_sh_d;
    logic signed [SUM_W-1:0]   sum_d;
    logic signed [ACC_W-1:0]   sat_d;
    logic signed [ACC_W-1:0]   int_d;
    logic signed [ACC_W-1:0]   u1_next_d;
    logic                      hi_d;
    logic                      lo_d;
    logic [PWM_W-1:0]          pwm_d;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        logic [SUM_W-ACC_W:0] top;
        top = v[SUM_W-1:ACC_W-1];
        if ((top == {(SUM_W-ACC_W+1){1'b0}}) || (top == {(SUM_W-ACC_W+1){1'b1}})) begin
            sat_acc = v[ACC_W-1:0];
        end else if (!v[SUM_W-1]) begin
            sat_acc = {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sat_acc = {1'b1, {(ACC_W-1){1'b0}}};
        end
    endfunction

    // Channel history lookup and operand steering into the shared multiplier
    always_comb begin
        ch_ok_d = (ch_q < CH_W'(N_CH));
        idx_d   = ch_q[IDX_W-1:0];
        if (ch_ok_d) begin
            e1_d = e1_q[idx_d];
            u1_d = u1_q[idx_d];
        end else begin
            e1_d = {N_WIDTH{1'b0}};
            u1_d = {ACC_W{1'b0}};
        end
        if (state_q == ST_MUL_P) begin
            mul_a_d = DIF_W'(e_q) - DIF_W'(e1_d);
            mul_b_d = $signed({1'b0, kp_q});
        end else begin
            mul_a_d = DIF_W'(e_q);
            mul_b_d = $signed({1'b0, ki_q});
        end
        prod_d    = PRD_W'(mul_a_d) * PRD_W'(mul_b_d);
        prod_sh_d = SUM_W'(prod_d >>> Q);
    end

    // Accumulate, saturate to the accumulator range and map to a PWM command
    always_comb begin
        sum_d = SUM_W'(u1_d) + p_q + i_q;
        sat_d = sat_acc(sum_d);
        int_d = sat_d >>> Q;
        hi_d  = (int_d >= ACC_W'(HI_THR));
        lo_d  = sat_d[ACC_W-1] || (int_d <= ACC_W'(LO_THR));
        if (hi_d) begin
            pwm_d = {PWM_W{1'b1}};
        end else if (lo_d) begin
            pwm_d = {PWM_W{1'b0}};
        end else begin
            pwm_d = int_d[PWM_W-1:0];
        end
`ifdef PI_ANTIWINDUP_EN
        if (hi_d) begin
            u1_next_d = ACC_W'({{PWM_W{1'b1}}, {Q{1'b0}}});
        end else if (lo_d) begin
            u1_next_d = {ACC_W{1'b0}};
        end else begin
            u1_next_d = sat_d;
        end
`else
        u1_next_d = sat_d;
`endif
    end

    // Sequencer: accept, two multiplies, accumulate/commit, hold result until consumed
    always_ff @(posedge Prescaler_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_ch_q    <= {CH_W{1'b0}};
            out_pwm_q   <= {PWM_W{1'b0}};
            ch_q        <= {CH_W{1'b0}};
            e_q         <= {N_WIDTH{1'b0}};
            kp_q        <= {GAIN_W{1'b0}};
            ki_q        <= {GAIN_W{1'b0}};
            p_q         <= {SUM_W{1'b0}};
            i_q         <= {SUM_W{1'b0}};
            pwm_bus_q   <= {(N_CH*PWM_W){1'b0}};
            for (int c = 0; c < N_CH; c++) begin
                e1_q[c] <= {N_WIDTH{1'b0}};
                u1_q[c] <= {ACC_W{1'b0}};
            end
        end else if (clear_all) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_ch_q    <= {CH_W{1'b0}};
            out_pwm_q   <= {PWM_W{1'b0}};
            pwm_bus_q   <= {(N_CH*PWM_W){1'b0}};
            for (int c = 0; c < N_CH; c++) begin
                e1_q[c] <= {N_WIDTH{1'b0}};
                u1_q[c] <= {ACC_W{1'b0}};
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_if.in_valid) begin
                        ch_q       <= req_if.in_ch;
                        e_q        <= req_if.in_error;
                        kp_q       <= req_if.kp;
                        ki_q       <= req_if.ki;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_MUL_P;
                    end
                end
                ST_MUL_P: begin
                    p_q     <= prod_sh_d;
                    state_q <= ST_MUL_I;
                end
                ST_MUL_I: begin
                    i_q     <= prod_sh_d;
                    state_q <= ST_ACC;
                end
                ST_ACC: begin
                    if (ch_ok_d) begin
                        e1_q[idx_d] <= e_q;
                        u1_q[idx_d] <= u1_next_d;
                        pwm_bus_q[int'(idx_d)*PWM_W +: PWM_W] <= pwm_d;
                    end
                    out_ch_q    <= ch_q;
                    out_pwm_q   <= ch_ok_d ? pwm_d : {PWM_W{1'b0}};
                    out_err_q   <= !ch_ok_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (req_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_if.in_ready  = in_ready_q;
    assign req_if.out_valid = out_valid_q;
    assign req_if.out_ch    = out_ch_q;
    assign req_if.out_pwm   = out_pwm_q;
    assign req_if.out_err   = out_err_q;
    assign pwm_bus          = pwm_bus_q;
endmodule
